wm_phase_timer: RTL and testbench
=================================

Name: wm_phase_timer

Overview:
Phase-duration responder for the washing-machine controller. It watches the controller's 3-bit state output, times each timed wash phase, and returns the one-cycle sig_Time_Out pulse the controller consumes to advance phases. It also freezes timing on fault inputs and drives the door-lock output. It sits beside the controller, closing the state -> sig_Time_Out loop that benches currently drive by hand.

Parameters:
CNT_W, 8, width of the phase countdown counter
DUR_SOAK, 4, cycles spent in SOAK (state 3'd1) before time-out
DUR_WASH, 6, cycles spent in WASH (state 3'd2) before time-out
DUR_RINSE, 4, cycles spent in RINSE (state 3'd3) before time-out
DUR_SPIN, 3, cycles spent in SPIN (state 3'd4) before time-out

Ports:
clock  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
state  input  3  controller state: 0 IDLE, 1 SOAK, 2 WASH, 3 RINSE, 4 SPIN, 5-7 untimed
sig_Out_Of_Balance  input  1  drum imbalance; freezes the count in SPIN only
sig_Motor_Failure  input  1  motor fault; freezes the count in any timed phase
sig_Time_Out  output  1  one-cycle pulse when the current phase duration expires
remaining  output  CNT_W  cycles left in the current phase; 0 when untimed or expired
door_lock  output  1  high while state is 1..4

Behaviour:
- One clock (clock); reset is asynchronous and active-high. All outputs are registered.
- Reset values: state_q=3'd0, remaining=0, sig_Time_Out=0, door_lock=0, expired=0.
- Internal state: state_q (last sampled state) and expired flag.
- Change edge (state != state_q):
  - state_q<=state; sig_Time_Out<=0; expired<=0.
  - remaining<=DUR(state) for states 1..4, else 0.
  - The reload takes priority over freeze and countdown.
- Countdown edge (state == state_q, timed state, not frozen, remaining != 0):
  - remaining<=remaining-1.
  - If remaining==1, sig_Time_Out<=1 and expired<=1; otherwise sig_Time_Out<=0.
- Latency: the change is registered at edge E0, remaining=DUR after E0, and sig_Time_Out is high exactly between edges E_DUR and E_DUR+1 (no freezes).
- Frozen: frozen = sig_Motor_Failure | (sig_Out_Of_Balance & state==3'd4).
  - remaining holds and sig_Time_Out<=0.
  - A freeze on the same edge that remaining would go 1->0 suppresses that pulse; it fires on the first unfrozen edge.
- Expired: remaining==0 and expired=1.
  - sig_Time_Out<=0 and no further pulses until a state change.
  - Exactly one pulse is emitted per phase entry.
- Untimed states (0, 5, 6, 7): remaining=0, no pulse, freeze ignored.
- Re-entry: the same state value cannot retrigger without an intervening change. A->B->A on consecutive edges reloads on each change.
- door_lock<=(state>=1 && state<=4), sampled every edge with 1-cycle latency.
- Reset mid-phase:
  - Outputs clear immediately (asynchronously); an in-flight pulse is cut.
  - After release, state_q=0. A nonzero state at the first edge counts as a change and reloads.
- Width rules:
  - Each DUR_* must be in 1..2^CNT_W-1; elaboration fails otherwise.
  - remaining never wraps below 0.
- No combinational path from any input to any output.

Test Plan:
- Reset high, state=2, clocks run -> remaining=0, sig_Time_Out=0, door_lock=0. Release reset -> next edge remaining=6, door_lock=1.
- state 0->1 at E0, held -> remaining 4,3,2,1,0 after E0..E4. sig_Time_Out high only in E4..E5. Afterwards no pulse for 10 more cycles.
- state=4, assert sig_Out_Of_Balance for cycles 2-4 of SPIN -> remaining holds at 1 during the freeze. The pulse arrives 3 cycles late. The same imbalance in state=2 has no effect (pulse at E6).
- Sequence 1->2->3->4->0, advancing each phase on its sig_Time_Out -> pulses after 4, 6, 4 and 3 cycles. remaining=0 and door_lock=0 in IDLE.
- state=2, change to 3 at remaining==1 -> no WASH pulse; remaining=4 after the edge.
- state=3 at remaining=2, assert reset for 1 cycle -> sig_Time_Out, remaining and door_lock go 0 asynchronously. After release remaining reloads to 4.

Source files
------------

// File: rtl/wm_phase_timer.sv
// Phase-duration timer for the washing-machine controller: times each wash phase,
// emits one sig_Time_Out pulse per phase entry, freezes on faults and drives door_lock.
module wm_phase_timer #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned DUR_SOAK  = 4,
  parameter int unsigned DUR_WASH  = 6,
  parameter int unsigned DUR_RINSE = 4,
  parameter int unsigned DUR_SPIN  = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       state,
  input  logic             sig_Out_Of_Balance,
  input  logic             sig_Motor_Failure,
  output logic             sig_Time_Out,
  output logic [CNT_W-1:0] remaining,
  output logic             door_lock
);

  localparam int unsigned ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_SOAK  = 3'd1;
  localparam logic [ST_W-1:0] ST_WASH  = 3'd2;
  localparam logic [ST_W-1:0] ST_RINSE = 3'd3;
  localparam logic [ST_W-1:0] ST_SPIN  = 3'd4;

  localparam longint unsigned CNT_MAX = (64'(1) << CNT_W) - 64'(1);

  // Every duration must be nonzero and representable in the countdown counter.
  if (CNT_W < 1 || CNT_W > 63) begin : g_bad_cnt_w
    $error("wm_phase_timer: CNT_W must be in 1..63");
  end
  if (64'(DUR_SOAK) == 64'd0 || 64'(DUR_SOAK) > CNT_MAX) begin : g_bad_soak
    $error("wm_phase_timer: DUR_SOAK out of range for CNT_W");
  end
  if (64'(DUR_WASH) == 64'd0 || 64'(DUR_WASH) > CNT_MAX) begin : g_bad_wash
    $error("wm_phase_timer: DUR_WASH out of range for CNT_W");
  end
  if (64'(DUR_RINSE) == 64'd0 || 64'(DUR_RINSE) > CNT_MAX) begin : g_bad_rinse
    $error("wm_phase_timer: DUR_RINSE out of range for CNT_W");
  end
  if (64'(DUR_SPIN) == 64'd0 || 64'(DUR_SPIN) > CNT_MAX) begin : g_bad_spin
    $error("wm_phase_timer: DUR_SPIN out of range for CNT_W");
  end

  function automatic logic is_timed(input logic [ST_W-1:0] s);
    return (s >= ST_SOAK) && (s <= ST_SPIN);
  endfunction

  function automatic logic [CNT_W-1:0] phase_dur(input logic [ST_W-1:0] s);
    logic [CNT_W-1:0] d;
    d = '0;
    case (s)
      ST_SOAK:  d = CNT_W'(DUR_SOAK);
      ST_WASH:  d = CNT_W'(DUR_WASH);
      ST_RINSE: d = CNT_W'(DUR_RINSE);
      ST_SPIN:  d = CNT_W'(DUR_SPIN);
      default:  d = '0;
    endcase
    return d;
  endfunction

  logic [ST_W-1:0]  state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             time_out_q, time_out_d;
  logic             expired_q, expired_d;
  logic             door_lock_q, door_lock_d;
  logic             frozen;

  // Imbalance only matters while spinning; a motor fault stalls any timed phase.
  assign frozen = sig_Motor_Failure | (sig_Out_Of_Balance & (state == ST_SPIN));

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    time_out_d  = 1'b0;
    expired_d   = expired_q;
    door_lock_d = is_timed(state);

    if (state != state_q) begin
      // A phase change reloads unconditionally, ahead of any freeze.
      state_d     = state;
      expired_d   = 1'b0;
      remaining_d = phase_dur(state);
    end else if (is_timed(state) && !frozen && !expired_q &&
                 (remaining_q != '0)) begin
      remaining_d = remaining_q - CNT_W'(1);
      if (remaining_q == CNT_W'(1)) begin
        time_out_d = 1'b1;
        expired_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      time_out_q  <= 1'b0;
      expired_q   <= 1'b0;
      door_lock_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      time_out_q  <= time_out_d;
      expired_q   <= expired_d;
      door_lock_q <= door_lock_d;
    end
  end

  assign sig_Time_Out = time_out_q;
  assign remaining    = remaining_q;
  assign door_lock    = door_lock_q;

endmodule

// File: tb/tb_wm_phase_timer.sv
// Directed bench for wm_phase_timer: expected outputs are queued as each step is
// driven and checked one edge later (or immediately for asynchronous reset).
module tb_wm_phase_timer;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] state;
  logic       sig_Out_Of_Balance;
  logic       sig_Motor_Failure;
  logic       sig_Time_Out;
  logic [7:0] remaining;
  logic       door_lock;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      tag;
    logic [7:0] rem;
    logic       to;
    logic       lock;
  } exp_t;

  exp_t sb[$];

  wm_phase_timer #(
    .CNT_W(8), .DUR_SOAK(4), .DUR_WASH(6), .DUR_RINSE(4), .DUR_SPIN(3)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .state              (state),
    .sig_Out_Of_Balance (sig_Out_Of_Balance),
    .sig_Motor_Failure  (sig_Motor_Failure),
    .sig_Time_Out       (sig_Time_Out),
    .remaining          (remaining),
    .door_lock          (door_lock)
  );

  always #5 clock = ~clock;

  task automatic push_exp(input string tag, input int rem, input bit to, input bit lock);
    exp_t e;
    e.tag  = tag;
    e.rem  = 8'(rem);
    e.to   = to;
    e.lock = lock;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL sb_empty observed=0 entries expected=1 entry");
      return;
    end
    e = sb.pop_front();
    n_tests++;
    assert (remaining === e.rem) else begin
      n_fail++;
      $error("FAIL %s remaining observed=%0d expected=%0d", e.tag, remaining, e.rem);
    end
    n_tests++;
    assert (sig_Time_Out === e.to) else begin
      n_fail++;
      $error("FAIL %s sig_Time_Out observed=%b expected=%b", e.tag, sig_Time_Out, e.to);
    end
    n_tests++;
    assert (door_lock === e.lock) else begin
      n_fail++;
      $error("FAIL %s door_lock observed=%b expected=%b", e.tag, door_lock, e.lock);
    end
  endtask

  // One clock edge: queue what the outputs must be after it, then check #1 later.
  task automatic cyc(input string tag, input int rem, input bit to, input bit lock);
    push_exp(tag, rem, to, lock);
    @(posedge clock);
    #1;
    pop_check();
  endtask

  // Check without an edge, for asynchronous effects.
  task automatic now_chk(input string tag, input int rem, input bit to, input bit lock);
    push_exp(tag, rem, to, lock);
    pop_check();
  endtask

  int ph_st [4] = '{1, 2, 3, 4};
  int ph_dur[4] = '{4, 6, 4, 3};

  initial begin
    reset              = 1'b1;
    state              = 3'd2;
    sig_Out_Of_Balance = 1'b0;
    sig_Motor_Failure  = 1'b0;

    // Held in reset with WASH requested: everything stays clear.
    for (int i = 0; i < 3; i++) cyc("rst_hold", 0, 1'b0, 1'b0);
    reset = 1'b0;
    cyc("rst_release", 6, 1'b0, 1'b1);
    for (int k = 1; k <= 6; k++) cyc("wash_cnt", 6 - k, k == 6, 1'b1);
    state = 3'd0;
    cyc("idle", 0, 1'b0, 1'b0);

    // SOAK countdown, single pulse, then silence.
    state = 3'd1;
    cyc("soak_e0", 4, 1'b0, 1'b1);
    for (int k = 1; k <= 4; k++) cyc("soak_cnt", 4 - k, k == 4, 1'b1);
    for (int i = 0; i < 10; i++) cyc("soak_expired", 0, 1'b0, 1'b1);

    // SPIN with imbalance: holds at 1, pulse three cycles late.
    state = 3'd4;
    cyc("spin_e0", 3, 1'b0, 1'b1);
    cyc("spin_e1", 2, 1'b0, 1'b1);
    cyc("spin_e2", 1, 1'b0, 1'b1);
    sig_Out_Of_Balance = 1'b1;
    for (int i = 0; i < 3; i++) cyc("spin_frozen", 1, 1'b0, 1'b1);
    sig_Out_Of_Balance = 1'b0;
    cyc("spin_late_pulse", 0, 1'b1, 1'b1);
    cyc("spin_expired", 0, 1'b0, 1'b1);

    // Same imbalance during WASH is ignored.
    state = 3'd2;
    cyc("wash_oob_e0", 6, 1'b0, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      sig_Out_Of_Balance = (k >= 3 && k <= 5);
      cyc("wash_oob", 6 - k, k == 6, 1'b1);
    end
    sig_Out_Of_Balance = 1'b0;

    // Motor fault on the final edge suppresses the pulse until it clears.
    state = 3'd1;
    cyc("soak_mf_e0", 4, 1'b0, 1'b1);
    for (int k = 1; k <= 3; k++) cyc("soak_mf_cnt", 4 - k, 1'b0, 1'b1);
    sig_Motor_Failure = 1'b1;
    cyc("soak_mf_hold", 1, 1'b0, 1'b1);
    cyc("soak_mf_hold", 1, 1'b0, 1'b1);
    sig_Motor_Failure = 1'b0;
    cyc("soak_mf_release", 0, 1'b1, 1'b1);

    // Untimed state ignores the fault; reload beats an active freeze.
    state = 3'd5;
    sig_Motor_Failure = 1'b1;
    cyc("untimed", 0, 1'b0, 1'b0);
    cyc("untimed", 0, 1'b0, 1'b0);
    state = 3'd3;
    cyc("reload_frozen", 4, 1'b0, 1'b1);
    cyc("frozen_hold", 4, 1'b0, 1'b1);
    sig_Motor_Failure = 1'b0;
    cyc("frozen_release", 3, 1'b0, 1'b1);

    // Full cycle advancing each phase on its own pulse.
    state = 3'd0;
    cyc("seq_idle0", 0, 1'b0, 1'b0);
    for (int p = 0; p < 4; p++) begin
      state = 3'(ph_st[p]);
      cyc("seq_e0", ph_dur[p], 1'b0, 1'b1);
      for (int k = 1; k <= ph_dur[p]; k++)
        cyc("seq_cnt", ph_dur[p] - k, k == ph_dur[p], 1'b1);
    end
    state = 3'd0;
    cyc("seq_idle", 0, 1'b0, 1'b0);
    cyc("seq_idle", 0, 1'b0, 1'b0);

    // A->B->A on consecutive edges reloads every time.
    state = 3'd1; cyc("reenter_a", 4, 1'b0, 1'b1);
    state = 3'd2; cyc("reenter_b", 6, 1'b0, 1'b1);
    state = 3'd1; cyc("reenter_a2", 4, 1'b0, 1'b1);
    cyc("reenter_cnt", 3, 1'b0, 1'b1);

    // Leaving WASH at remaining==1 gives no WASH pulse.
    state = 3'd2;
    cyc("early_e0", 6, 1'b0, 1'b1);
    for (int k = 1; k <= 5; k++) cyc("early_cnt", 6 - k, 1'b0, 1'b1);
    state = 3'd3;
    cyc("early_change", 4, 1'b0, 1'b1);
    cyc("rinse_cnt", 3, 1'b0, 1'b1);
    cyc("rinse_cnt", 2, 1'b0, 1'b1);

    // Asynchronous reset mid-RINSE, then reload on the first edge after release.
    reset = 1'b1;
    #1;
    now_chk("rst_async", 0, 1'b0, 1'b0);
    cyc("rst_async_hold", 0, 1'b0, 1'b0);
    reset = 1'b0;
    cyc("rst_reload", 4, 1'b0, 1'b1);
    for (int k = 1; k <= 4; k++) cyc("rst_rinse_cnt", 4 - k, k == 4, 1'b1);

    // Reset lands while the pulse is high and cuts it.
    reset = 1'b1;
    #1;
    now_chk("rst_cut_pulse", 0, 1'b0, 1'b0);
    reset = 1'b0;
    state = 3'd0;
    cyc("post_rst_idle", 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
